// File: rtl/slip_tx.sv
// SLIP transmit framer: escapes packet-buffer bytes and appends END after the last byte of each packet.
// Optional macro SLIP_TX_SOF_EN: also emit a leading END in front of every frame.
module slip_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  input  logic       pkt_empty,
  output logic       pkt_rd,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ack,
  output logic [7:0] pkt_cnt
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  localparam logic [DW-1:0] END_B     = DW'(8'hC0);
  localparam logic [DW-1:0] ESC_B     = DW'(8'hDB);
  localparam logic [DW-1:0] ESC_END_B = DW'(8'hDC);
  localparam logic [DW-1:0] ESC_ESC_B = DW'(8'hDD);

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_ESC2 = 2'd1,
`ifdef SLIP_TX_SOF_EN
    ST_SOF  = 2'd3,
`endif
    ST_EOF  = 2'd2
  } state_e;

  // State entered after reset and after each trailing END.
`ifdef SLIP_TX_SOF_EN
  localparam state_e FRAME_START = ST_SOF;
`else
  localparam state_e FRAME_START = ST_DATA;
`endif

  state_e        state_q, state_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          ld_c;
  logic          rd_c;
  logic          special_c;

  assign ld_c      = ~out_valid_q | out_ack;
  assign special_c = (pkt_data == END_B) || (pkt_data == ESC_B);

  // Next-state, output-register and pop-strobe logic.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pkt_cnt_d   = pkt_cnt_q;
    rd_c        = 1'b0;

    if (ld_c) begin
      case (state_q)
`ifdef SLIP_TX_SOF_EN
        ST_SOF: begin
          if (!pkt_empty) begin
            out_data_d  = END_B;
            out_valid_d = 1'b1;
            state_d     = ST_DATA;
          end else begin
            out_valid_d = 1'b0;
          end
        end
`endif
        ST_DATA: begin
          if (pkt_empty) begin
            out_valid_d = 1'b0;
          end else if (special_c) begin
            out_data_d  = ESC_B;
            out_valid_d = 1'b1;
            state_d     = ST_ESC2;
          end else begin
            out_data_d  = pkt_data;
            out_valid_d = 1'b1;
            rd_c        = 1'b1;
            state_d     = pkt_last ? ST_EOF : ST_DATA;
          end
        end
        ST_ESC2: begin
          // The escaped byte is still at the buffer head; guard against a
          // buffer that drops it so a pop never happens while empty.
          if (pkt_empty) begin
            out_valid_d = 1'b0;
          end else begin
            out_data_d  = (pkt_data == END_B) ? ESC_END_B : ESC_ESC_B;
            out_valid_d = 1'b1;
            rd_c        = 1'b1;
            state_d     = pkt_last ? ST_EOF : ST_DATA;
          end
        end
        ST_EOF: begin
          out_data_d  = END_B;
          out_valid_d = 1'b1;
          pkt_cnt_d   = pkt_cnt_q + CW'(1);
          state_d     = FRAME_START;
        end
        default: begin
          out_valid_d = 1'b0;
          state_d     = FRAME_START;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FRAME_START;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  // Pop is masked during reset so the buffer never loses a byte while held.
  assign pkt_rd    = rd_c & rst_n;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_slip_tx.sv
// Self-checking bench for slip_tx: queue-based SLIP encoder model, FIFO source and random-ack sink.
module tb_slip_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pkt_data = 8'h55;
  logic       pkt_last = 1'b0;
  logic       pkt_empty = 1'b0;
  logic       out_ack = 1'b1;
  logic       pkt_rd;
  logic [7:0] out_data;
  logic       out_valid;
  logic [7:0] pkt_cnt;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  int rd_pulses = 0;
  int rd0 = 0;
  int flen = 0;

  logic [8:0] pend_q[$];
  logic [8:0] src_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pkt_buf[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  slip_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pkt_data (pkt_data),
    .pkt_last (pkt_last),
    .pkt_empty(pkt_empty),
    .pkt_rd   (pkt_rd),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: a packet becomes [END] + escaped payload + END on the wire.
  task automatic add_packet();
    int n;
    n = pkt_buf.size();
`ifdef SLIP_TX_SOF_EN
    exp_q.push_back(8'hC0);
`endif
    for (int i = 0; i < n; i++) begin
      pend_q.push_back({(i == n - 1), pkt_buf[i]});
      if (pkt_buf[i] == 8'hC0) begin
        exp_q.push_back(8'hDB);
        exp_q.push_back(8'hDC);
      end else if (pkt_buf[i] == 8'hDB) begin
        exp_q.push_back(8'hDB);
        exp_q.push_back(8'hDD);
      end else begin
        exp_q.push_back(pkt_buf[i]);
      end
    end
    exp_q.push_back(8'hC0);
    frames++;
    pkt_buf.delete();
  endtask

  // One clock: drive at negedge, sample 1 ns later, account for the coming posedge.
  task automatic step(input int ack_pct, input int push_pct);
    @(negedge clk);
    if (pend_q.size() > 0 && $urandom_range(99) < push_pct) begin
      if (push_pct >= 100) begin
        while (pend_q.size() > 0) src_q.push_back(pend_q.pop_front());
      end else begin
        src_q.push_back(pend_q.pop_front());
      end
    end
    pkt_empty = (src_q.size() == 0);
    if (!pkt_empty) {pkt_last, pkt_data} = src_q[0];
    else {pkt_last, pkt_data} = 9'($urandom);
    out_ack = ($urandom_range(99) < ack_pct);
    #1;
    if (prev_stall) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(prev_data));
    end
    if (pkt_empty) chk("rd_while_empty", 32'(pkt_rd), 32'd0);
    if (out_valid === 1'b1 && out_ack) begin
      if (exp_q.size() == 0) chk("extra_byte", 32'(out_data), 32'hFFFF_FFFF);
      else chk("stream", 32'(out_data), 32'(exp_q.pop_front()));
    end
    if (pkt_rd === 1'b1) begin
      rd_pulses++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    prev_stall = (out_valid === 1'b1) && !out_ack;
    prev_data  = out_data;
  endtask

  task automatic drain(input string tag, input int ack_pct, input int push_pct, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pend_q.size() > 0 || src_q.size() > 0) && n < max_cyc) begin
      step(ack_pct, push_pct);
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset values, with a readable byte present to exercise pop masking.
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_rd", 32'(pkt_rd), 32'd0);
    @(negedge clk);
    pkt_empty = 1'b1;
    rst_n = 1'b1;

    // Two plain bytes, full throughput: frame completes in length+1 cycles.
    pkt_buf = '{8'h01, 8'h02};
    add_packet();
    flen = exp_q.size();
    repeat (flen + 1) step(100, 100);
    chk("basic_len", 32'(exp_q.size()), 32'd0);
    chk("basic_cnt", 32'(pkt_cnt), 32'd1);
    step(100, 100);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Both special bytes escaped, two pops only.
    rd0 = rd_pulses;
    pkt_buf = '{8'hC0, 8'hDB};
    add_packet();
    flen = exp_q.size();
    repeat (flen + 1) step(100, 100);
    chk("esc_len", 32'(exp_q.size()), 32'd0);
    chk("esc_rd", 32'(rd_pulses - rd0), 32'd2);
    chk("esc_cnt", 32'(pkt_cnt), 32'd2);

    // Back-pressure mid-packet: output frozen, no pops, stream resumes intact.
    pkt_buf = '{8'h11, 8'h22, 8'h33, 8'h44};
    add_packet();
    repeat (3) step(100, 100);
    rd0 = rd_pulses;
    repeat (6) step(0, 100);
    chk("stall_rd", 32'(rd_pulses - rd0), 32'd0);
    drain("stall_drain", 100, 100, 50);
    chk("stall_cnt", 32'(pkt_cnt), 32'd3);

    // Random packets, random arrival gaps, random ack.
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(3))
          0: pkt_buf.push_back(8'hC0);
          1: pkt_buf.push_back(8'hDB);
          default: pkt_buf.push_back(8'($urandom));
        endcase
      end
      add_packet();
    end
    drain("rand_drain", 60, 40, 20000);
    chk("rand_cnt", 32'(pkt_cnt), 32'(frames % 256));

    // Reset mid-packet: immediate clear, partial frame abandoned.
    pkt_buf = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    add_packet();
    repeat (3) step(100, 100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_cnt", 32'(pkt_cnt), 32'd0);
    chk("midrst_rd", 32'(pkt_rd), 32'd0);
    pend_q.delete();
    src_q.delete();
    exp_q.delete();
    frames = 0;
    prev_stall = 1'b0;
    pkt_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    pkt_buf = '{8'h77};
    add_packet();
    drain("postrst_drain", 100, 100, 50);
    chk("postrst_cnt", 32'(pkt_cnt), 32'd1);

    // Counter wrap: 255 frames since reset, then the 256th returns to zero.
    for (int p = 0; p < 254; p++) begin
      pkt_buf.push_back(8'($urandom));
      add_packet();
    end
    drain("wrap_drain", 100, 100, 4000);
    chk("cnt_255", 32'(pkt_cnt), 32'd255);
    pkt_buf = '{8'hC0};
    add_packet();
    drain("wrap_last", 100, 100, 50);
    chk("cnt_wrap", 32'(pkt_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
